// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Stage-entry type and constants shared by the hazard tracker.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Entry rd width; the tracker's REG_AW must equal this value.
    localparam int ENTRY_RD_W = 5;
    localparam int MUL_CNT_W  = 4;

    typedef struct packed {
        logic [ENTRY_RD_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mul;
    } stage_entry_t;

    localparam logic [ENTRY_RD_W-1:0] REG_ZERO     = '0;
    localparam stage_entry_t          BUBBLE_ENTRY = '0;

endpackage
`default_nettype wire

// File: rtl/mul_busy_counter.sv
`default_nettype none
// ============================================================================
// Module   : mul_busy_counter
// Purpose  : Counts remaining EX cycles of a multi-cycle multiply.
// Revision : 1.0 - initial release
// ============================================================================
module mul_busy_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_tracker
// Purpose  : Tracks EX/MEM/WB destination metadata for forwarding and raises
//            load-use / multiply stalls and EX bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mul,
    input  logic              flush,
    output logic              stall,
    output logic              ex_bubble,
    output logic              ex_busy,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic              ex_reg_write,
    output logic              mem_reg_write,
    output logic              wb_reg_write,
    output logic              ex_mem_read
);

    localparam logic [MUL_CNT_W-1:0] c_mul_load = MUL_CNT_W'(MUL_LAT - 1);

    stage_entry_t r_ex;
    stage_entry_t r_mem;
    stage_entry_t r_wb;
    stage_entry_t w_id_entry;
    logic         w_load_use;
    logic         w_ex_busy;
    logic         w_mul_start;

    // Writes to r0 are architecturally dead, so they never produce a hazard.
    always_comb begin
        w_id_entry           = BUBBLE_ENTRY;
        w_id_entry.rd        = id_rd;
        w_id_entry.reg_write = id_reg_write & (id_rd != REG_ZERO);
        w_id_entry.mem_read  = id_mem_read;
        w_id_entry.mul       = id_mul;
    end

    assign w_load_use = r_ex.mem_read & r_ex.reg_write & (r_ex.rd != REG_ZERO) &
                        ((r_ex.rd == id_rs) | (id_uses_rt & (r_ex.rd == id_rt)));

    assign stall       = id_valid & ~flush & (w_load_use | w_ex_busy);
    assign ex_bubble   = ~w_ex_busy & (~id_valid | flush | w_load_use);
    assign w_mul_start = ~w_ex_busy & ~ex_bubble & id_mul;

    mul_busy_counter #(
        .CNT_W (MUL_CNT_W)
    ) u_mul_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_mul_start),
        .i_load_val (c_mul_load),
        .i_dec      (w_ex_busy),
        .o_busy     (w_ex_busy)
    );

    // A busy multiply freezes EX and starves MEM; older entries always drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= BUBBLE_ENTRY;
            r_mem <= BUBBLE_ENTRY;
            r_wb  <= BUBBLE_ENTRY;
        end else begin
            r_wb <= r_mem;
            if (w_ex_busy) begin
                r_mem <= BUBBLE_ENTRY;
            end else begin
                r_mem <= r_ex;
                r_ex  <= ex_bubble ? BUBBLE_ENTRY : w_id_entry;
            end
        end
    end

    assign ex_busy       = w_ex_busy;
    assign ex_rd         = r_ex.rd;
    assign mem_rd        = r_mem.rd;
    assign wb_rd         = r_wb.rd;
    assign ex_reg_write  = r_ex.reg_write;
    assign mem_reg_write = r_mem.reg_write;
    assign wb_reg_write  = r_wb.reg_write;
    assign ex_mem_read   = r_ex.mem_read;

endmodule
`default_nettype wire
